seven_seg_scan_driver: RTL and testbench
========================================

# seven_seg_scan_driver

Time-multiplexed seven-segment display driver that sits downstream of the cascaded BCD digit counters. It takes a packed bus of 4-bit digit values plus decimal points and scans them across a common-anode display, one digit slot at a time. It latches a full frame snapshot so digits never tear mid-scan, and inserts a per-slot anode blanking interval to suppress ghosting.

## Interface
- NUM_DIGITS, 4: number of display digits; index 0 is the least significant (rightmost) digit; range 2..8.
- REFRESH_DIV, 100000: w_CLK cycles per digit slot; must be ≥ 2.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.
- DISPLAY_MODE, "DECIMAL": set to "DECIMAL" or "HEXADECIMAL"; any other value behaves as "DECIMAL".
- Reset and clock: reset w_RST, asynchronous, active-high; clock w_CLK.
- w_CLK  in  1  system clock.
- w_RST  in  1  asynchronous active-high reset.
- i_DIGITS  in  4*NUM_DIGITS  packed digit values; digit k occupies [4k+3:4k].
- i_DP  in  NUM_DIGITS  decimal point request per digit, active-high.
- o_AN  out  NUM_DIGITS  anode enables, active-low, one-hot-low or all ones.
- o_SEG  out  7  segments {g,f,e,d,c,b,a}, active-low.
- o_DP  out  1  decimal point segment, active-low.
- o_FRAME  out  1  one-cycle pulse when a new snapshot is latched.

## Operation
- **Prescaler:** r_PRE counts 0..REFRESH_DIV-1 and wraps to 0. Width is $clog2(REFRESH_DIV).
- **Digit index:** r_IDX advances by 1, modulo NUM_DIGITS, on the cycle where r_PRE == REFRESH_DIV-1.
- **Snapshot:** r_SNAP ← {i_DIGITS, i_DP} on the cycle where r_PRE == REFRESH_DIV-1 and r_IDX == NUM_DIGITS-1, i.e. as the index wraps to 0. On that same cycle o_FRAME is asserted, registered so it is visible the next cycle. Between snapshots, input changes are ignored.
- **Decode:** the current nibble is r_SNAP digit r_IDX.
  - Values 0–9 map to the standard glyphs: 0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000.
  - In HEXADECIMAL mode, 10–15 map to the glyphs A, b, C, d, E, F.
  - In DECIMAL mode, 10–15 map to blank (7'h7F).
- **Anodes:** o_AN is all ones while r_PRE < BLANK_CYCLES. Otherwise o_AN = ~(1 << r_IDX).
- **Decimal point:** o_DP = ~dp[r_IDX].
- **Segments during blanking:** o_SEG still carries the decoded glyph; only the anodes are blanked.

## Timing
- All outputs are registered. Each output reflects r_PRE and r_IDX from the previous cycle, so latency from an index/prescaler state to the pins is 1 cycle.
- An input change reaches the display no earlier than the next snapshot. Worst case is NUM_DIGITS·REFRESH_DIV + 1 cycles.
- Reset values:
  - Internal: r_PRE = 0, r_IDX = 0, r_SNAP = 0.
  - Outputs: o_AN = all ones, o_SEG = 7'h7F, o_DP = 1, o_FRAME = 0.
- **First frame after reset:** the display shows the zero snapshot (glyph "0" on every digit, subject to LZB) until the first o_FRAME.
- **Reset mid-scan:** all state returns to reset values immediately. No partial-frame output follows the deassertion of reset.
- **Wrap:** the last slot of a frame (r_IDX = NUM_DIGITS-1) is followed directly by slot 0 with the new snapshot. There is no gap beyond the normal BLANK_CYCLES.
- **Simultaneous events:** an input change on the snapshot cycle is captured; the value sampled is the one at that clock edge.

## Configuration
- **Macro:** SEVEN_SEG_LZB_EN.
- **With the macro defined (leading-zero blanking):** digit k > 0 is blanked (o_SEG = 7'h7F) when snapshot digits NUM_DIGITS-1 down to k are all zero. Digit 0 is never blanked. o_DP is unaffected, and anode scanning is unchanged.
- **Without the macro:** every digit is decoded normally. The LZB logic is absent from the netlist.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1.
- **Reset:** assert w_RST mid-slot → the same cycle shows o_AN=4'hF, o_SEG=7'h7F, o_DP=1, o_FRAME=0; after release, r_IDX restarts at 0.
- **Scan order:** i_DIGITS=16'h4321, i_DP=0, wait for o_FRAME → o_AN sequence per frame is 1111, 1110×3, 1111, 1101×3, 1111, 1011×3, 1111, 0111×3, with o_SEG equal to glyphs 1, 2, 3, 4 in step.
- **Snapshot stability:** change i_DIGITS from 16'h1234 to 16'h9999 mid-frame → the remaining slots of that frame still show 1234; 9999 appears only after the next o_FRAME, which pulses every 16 cycles.
- **Decimal vs hex:** i_DIGITS=16'h00AF → DECIMAL mode blanks digits 0 and 1; HEXADECIMAL mode shows F = 7'b0001110 and A = 7'b0001000.
- **Decimal point:** i_DP=4'b0100 → o_DP=0 only while o_AN=1011, and o_DP=1 in every other slot.
- **LZB (macro defined):** i_DIGITS=16'h0050 → digits 3 and 2 blank, digit 1 shows 5, digit 0 shows 0; i_DIGITS=16'h0000 → only digit 0 shows 0.

Source files
------------

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment scan driver with frame snapshot and anode blanking.
// Optional leading-zero blanking is compiled in with `define SEVEN_SEG_LZB_EN.
module seven_seg_scan_driver #(
  parameter int    NUM_DIGITS   = 4,
  parameter int    REFRESH_DIV  = 100000,
  parameter int    BLANK_CYCLES = 1000,
  parameter string DISPLAY_MODE = "DECIMAL"
) (
  input  logic                    w_CLK,
  input  logic                    w_RST,
  input  logic [4*NUM_DIGITS-1:0] i_DIGITS,
  input  logic [NUM_DIGITS-1:0]   i_DP,
  output logic [NUM_DIGITS-1:0]   o_AN,
  output logic [6:0]              o_SEG,
  output logic                    o_DP,
  output logic                    o_FRAME
);

  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [PRE_W-1:0]      PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
  localparam logic [PRE_W-1:0]      BLANK_LIM = PRE_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{1'b1}};
  localparam logic [NUM_DIGITS-1:0] AN_ONE    = {{(NUM_DIGITS-1){1'b0}}, 1'b1};
  localparam bit                    HEX_MODE  = (DISPLAY_MODE == "HEXADECIMAL");

  // Active-low {g,f,e,d,c,b,a}; 10..15 are letters only when hex glyphs are enabled.
  function automatic logic [6:0] glyph(input logic [3:0] nib, input bit hex);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'b1000000;
      4'h1:    g = 7'b1111001;
      4'h2:    g = 7'b0100100;
      4'h3:    g = 7'b0110000;
      4'h4:    g = 7'b0011001;
      4'h5:    g = 7'b0010010;
      4'h6:    g = 7'b0000010;
      4'h7:    g = 7'b1111000;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0010000;
      4'hA:    g = hex ? 7'b0001000 : 7'h7F;
      4'hB:    g = hex ? 7'b0000011 : 7'h7F;
      4'hC:    g = hex ? 7'b1000110 : 7'h7F;
      4'hD:    g = hex ? 7'b0100001 : 7'h7F;
      4'hE:    g = hex ? 7'b0000110 : 7'h7F;
      4'hF:    g = hex ? 7'b0001110 : 7'h7F;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  logic [PRE_W-1:0]        pre_q, pre_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] snap_dig_q, snap_dig_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    frame_q, frame_d;

  logic                    slot_end_s;
  logic                    frame_end_s;
  logic [3:0]              nib_s;
`ifdef SEVEN_SEG_LZB_EN
  logic                    lz_blank_s;
`endif

  // Next-state for scan counters and snapshot, plus decode of the next output values.
  always_comb begin
    slot_end_s  = (pre_q == PRE_LAST);
    frame_end_s = slot_end_s && (idx_q == IDX_LAST);

    pre_d = slot_end_s ? {PRE_W{1'b0}} : pre_q + PRE_W'(1);
    idx_d = slot_end_s ? ((idx_q == IDX_LAST) ? {IDX_W{1'b0}} : idx_q + IDX_W'(1)) : idx_q;

    snap_dig_d = frame_end_s ? i_DIGITS : snap_dig_q;
    snap_dp_d  = frame_end_s ? i_DP     : snap_dp_q;

    nib_s = snap_dig_q[4*int'(idx_q) +: 4];

`ifdef SEVEN_SEG_LZB_EN
    // Blank when this digit and every more-significant digit is zero; digit 0 always shows.
    lz_blank_s = (idx_q != {IDX_W{1'b0}});
    for (int k = 0; k < NUM_DIGITS; k++) begin
      lz_blank_s = lz_blank_s &
                   ~((int'(idx_q) <= k) && (snap_dig_q[4*k +: 4] != 4'h0));
    end
    seg_d = lz_blank_s ? 7'h7F : glyph(nib_s, HEX_MODE);
`else
    seg_d = glyph(nib_s, HEX_MODE);
`endif

    an_d    = (pre_q < BLANK_LIM) ? AN_OFF : ~(AN_ONE << idx_q);
    dp_d    = ~snap_dp_q[idx_q];
    frame_d = frame_end_s;
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge w_CLK or posedge w_RST) begin
    if (w_RST) begin
      pre_q      <= {PRE_W{1'b0}};
      idx_q      <= {IDX_W{1'b0}};
      snap_dig_q <= {(4*NUM_DIGITS){1'b0}};
      snap_dp_q  <= {NUM_DIGITS{1'b0}};
      an_q       <= AN_OFF;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
      frame_q    <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      idx_q      <= idx_d;
      snap_dig_q <= snap_dig_d;
      snap_dp_q  <= snap_dp_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      frame_q    <= frame_d;
    end
  end

  assign o_AN    = an_q;
  assign o_SEG   = seg_q;
  assign o_DP    = dp_q;
  assign o_FRAME = frame_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Randomized bench for seven_seg_scan_driver (decimal and hex instances) against a
// cycle-count reference model; honours SEVEN_SEG_LZB_EN when defined.
module tb_seven_seg_scan_driver;

  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int FR    = N * DIV;

  logic        w_CLK = 1'b0;
  logic        w_RST = 1'b1;
  logic [15:0] i_DIGITS = 16'h0000;
  logic [3:0]  i_DP = 4'h0;

  logic [3:0]  an_dec, an_hex;
  logic [6:0]  seg_dec, seg_hex;
  logic        dp_dec, dp_hex;
  logic        frame_dec, frame_hex;

  seven_seg_scan_driver #(
    .NUM_DIGITS(N), .REFRESH_DIV(DIV), .BLANK_CYCLES(BLANK), .DISPLAY_MODE("DECIMAL")
  ) dut_dec (
    .w_CLK(w_CLK), .w_RST(w_RST), .i_DIGITS(i_DIGITS), .i_DP(i_DP),
    .o_AN(an_dec), .o_SEG(seg_dec), .o_DP(dp_dec), .o_FRAME(frame_dec)
  );

  seven_seg_scan_driver #(
    .NUM_DIGITS(N), .REFRESH_DIV(DIV), .BLANK_CYCLES(BLANK), .DISPLAY_MODE("HEXADECIMAL")
  ) dut_hex (
    .w_CLK(w_CLK), .w_RST(w_RST), .i_DIGITS(i_DIGITS), .i_DP(i_DP),
    .o_AN(an_hex), .o_SEG(seg_hex), .o_DP(dp_hex), .o_FRAME(frame_hex)
  );

  always #5 w_CLK = ~w_CLK;

  // Glyph table for 0..F, active-low {g,f,e,d,c,b,a}.
  logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int         n_checks = 0;
  int         n_pass   = 0;
  int         s        = 0;
  logic [3:0] m_dig [N];
  logic       m_dp  [N];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, s);
  endtask

  task automatic model_reset();
    s = 0;
    for (int k = 0; k < N; k++) begin
      m_dig[k] = 4'h0;
      m_dp[k]  = 1'b0;
    end
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_an_dec",    {28'h0, an_dec},    32'hF);
    check_eq("rst_seg_dec",   {25'h0, seg_dec},   32'h7F);
    check_eq("rst_dp_dec",    {31'h0, dp_dec},    32'h1);
    check_eq("rst_frame_dec", {31'h0, frame_dec}, 32'h0);
    check_eq("rst_seg_hex",   {25'h0, seg_hex},   32'h7F);
    check_eq("rst_an_hex",    {28'h0, an_hex},    32'hF);
  endtask

  // Advance one clock; outputs after the edge reflect the scan position held before it.
  task automatic step();
    int         pre, idx;
    logic [3:0] nib, e_an;
    logic [6:0] e_dec, e_hex;
    logic       e_dp, e_frame, capture, lz;
    pre   = s % DIV;
    idx   = (s / DIV) % N;
    nib   = m_dig[idx];
    e_hex = GLYPH[nib];
    e_dec = (nib < 4'd10) ? GLYPH[nib] : 7'h7F;
    lz    = 1'b0;
`ifdef SEVEN_SEG_LZB_EN
    lz = (idx > 0);
    for (int j = idx; j < N; j++) if (m_dig[j] != 4'h0) lz = 1'b0;
`endif
    if (lz) begin
      e_dec = 7'h7F;
      e_hex = 7'h7F;
    end
    e_an = 4'hF;
    if (pre >= BLANK) e_an[idx] = 1'b0;
    e_dp    = ~m_dp[idx];
    e_frame = ((s % FR) == FR - 1);
    capture = e_frame;
    @(posedge w_CLK);
    if (capture) begin
      for (int k = 0; k < N; k++) begin
        m_dig[k] = i_DIGITS[4*k +: 4];
        m_dp[k]  = i_DP[k];
      end
    end
    s++;
    @(negedge w_CLK);
    check_eq("an",    {28'h0, an_dec},    {28'h0, e_an});
    check_eq("seg",   {25'h0, seg_dec},   {25'h0, e_dec});
    check_eq("dp",    {31'h0, dp_dec},    {31'h0, e_dp});
    check_eq("frame", {31'h0, frame_dec}, {31'h0, e_frame});
    check_eq("seg_hex", {25'h0, seg_hex}, {25'h0, e_hex});
    check_eq("an_hex",  {28'h0, an_hex},  {28'h0, e_an});
    check_eq("dp_hex",  {31'h0, dp_hex},  {31'h0, e_dp});
    check_eq("frame_hex", {31'h0, frame_hex}, {31'h0, e_frame});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic mid_scan_reset();
    @(negedge w_CLK);
    w_RST = 1'b1;
    #1;
    check_reset_outputs();
    @(posedge w_CLK);
    @(negedge w_CLK);
    check_reset_outputs();
    w_RST = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    @(negedge w_CLK);
    check_reset_outputs();
    @(negedge w_CLK);
    w_RST = 1'b0;

    // Zero snapshot until first frame, then scan order with 4321.
    i_DIGITS = 16'h4321; i_DP = 4'h0;
    run(2 * FR + 3);

    // Snapshot stability: change mid-frame.
    i_DIGITS = 16'h1234;
    run(FR + 5);
    i_DIGITS = 16'h9999;
    run(2 * FR);

    // Letters: decimal blanks them, hex shows A/F.
    i_DIGITS = 16'h00AF;
    run(2 * FR);

    // Decimal point on digit 2 only.
    i_DP = 4'b0100; i_DIGITS = 16'h8765;
    run(2 * FR);
    i_DP = 4'h0;

    // Leading-zero patterns (normal decode when blanking is compiled out).
    i_DIGITS = 16'h0050;
    run(2 * FR);
    i_DIGITS = 16'h0000;
    run(2 * FR);
    i_DIGITS = 16'h0300;
    run(2 * FR);

    // Reset in the middle of a slot, then restart from slot 0 with zero snapshot.
    i_DIGITS = 16'h5A5A; i_DP = 4'hF;
    run(6);
    mid_scan_reset();
    run(2 * FR);

    // Randomized phase with occasional input changes and one more reset.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        i_DIGITS = 16'($urandom);
        if ($urandom_range(0, 1) == 0) i_DIGITS[15:8] = 8'h00;
        i_DP = 4'($urandom);
      end
      if (i == 217) mid_scan_reset();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
